uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 24 ++
 rtl/uart_rx_core.sv | 162 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: parity modes, FSM state encoding
// and a bit-voting helper.
package uart_pkg;

    localparam int CHECK_NONE = 0;
    localparam int CHECK_ODD  = 1;
    localparam int CHECK_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line plus a falling-edge detector on
// the synchronized value. All flops preset to 1 (idle line).
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic line,
    output logic rx,
    output logic fall
);

    logic [2:0] pipe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe <= '1;
        end else begin
            pipe <= {pipe[1:0], line};
        end
    end

    assign rx   = pipe[1];
    assign fall = pipe[2] & ~pipe[1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core: start/data/parity/stop framing with centre sampling.
// Define UART_RX_MAJORITY_EN to vote each bit over samples MID-1, MID, MID+1.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int P_SYSTEM_CLK      = 50_000_000,
    parameter int P_UART_BUADRATE   = 9600,
    parameter int P_UART_DATA_WIDTH = 8,
    parameter int P_UART_STOP_WIDTH = 1,
    parameter int P_UART_CHECK      = 0
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_uart_rx,
    output logic [P_UART_DATA_WIDTH-1:0] o_user_rx_data,
    output logic                         o_user_rx_valid,
    output logic                         o_user_rx_err,
    output logic                         o_user_rx_busy
);

    localparam int DIV   = P_SYSTEM_CLK / P_UART_BUADRATE;
    localparam int MID   = DIV / 2;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
`ifdef UART_RX_MAJORITY_EN
    localparam int SAMPLE_AT = MID + 1;
`else
    localparam int SAMPLE_AT = MID;
`endif
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_AT);

    rx_state_t state, next_state;

    logic                         rx;
    logic                         fall;
    logic [CNT_W-1:0]             cnt;
    logic [3:0]                   bit_cnt;
    logic                         stop_cnt;
    logic [P_UART_DATA_WIDTH-1:0] shreg;
    logic                         par_err;
    logic                         frame_err;
    logic                         sample_tick;
    logic                         bit_val;
    logic                         last_data;
    logic                         last_stop;
    logic                         parity_exp;
    logic                         frame_start;
    logic                         frame_done;

    uart_rx_sync u_sync (
        .clk  (i_clk),
        .rst  (i_rst),
        .line (i_uart_rx),
        .rx   (rx),
        .fall (fall)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] early;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            early <= '0;
        end else begin
            if (cnt == CNT_W'(MID - 1)) early[0] <= rx;
            if (cnt == CNT_W'(MID))     early[1] <= rx;
        end
    end

    assign bit_val = majority3(early[0], early[1], rx);
`else
    assign bit_val = rx;
`endif

    assign sample_tick = (cnt == CNT_SAMPLE);
    assign last_data   = (bit_cnt == 4'(P_UART_DATA_WIDTH - 1));
    assign last_stop   = (P_UART_STOP_WIDTH == 1) ? 1'b1 : stop_cnt;
    assign parity_exp  = (P_UART_CHECK == CHECK_ODD) ? ~^shreg : ^shreg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (fall) next_state = ST_START;
            ST_START:  if (sample_tick) next_state = bit_val ? ST_IDLE : ST_DATA;
            ST_DATA:   if (sample_tick && last_data)
                           next_state = (P_UART_CHECK == CHECK_NONE) ? ST_STOP : ST_PARITY;
            ST_PARITY: if (sample_tick) next_state = ST_STOP;
            ST_STOP:   if (sample_tick && last_stop)
                           next_state = fall ? ST_START : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_user_rx_busy = (state != ST_IDLE);
        frame_done     = (state == ST_STOP) && sample_tick && last_stop;
        frame_start    = (next_state == ST_START) && (state != ST_START);
    end

    // Frame-start clears come last so a back-to-back start overrides the stop update.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt             <= '0;
            bit_cnt         <= '0;
            stop_cnt        <= 1'b0;
            shreg           <= '0;
            par_err         <= 1'b0;
            frame_err       <= 1'b0;
            o_user_rx_data  <= '0;
            o_user_rx_valid <= 1'b0;
            o_user_rx_err   <= 1'b0;
        end else begin
            o_user_rx_valid <= 1'b0;
            o_user_rx_err   <= 1'b0;

            if (o_user_rx_busy) begin
                cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
            end

            if (sample_tick) begin
                unique case (state)
                    ST_DATA: begin
                        shreg   <= {bit_val, shreg[P_UART_DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                    end
                    ST_PARITY: par_err <= (bit_val != parity_exp);
                    ST_STOP: begin
                        if (!bit_val) frame_err <= 1'b1;
                        stop_cnt <= stop_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end

            if (frame_done) begin
                o_user_rx_data <= shreg;
                if (frame_err || !bit_val || par_err) begin
                    o_user_rx_err <= 1'b1;
                end else begin
                    o_user_rx_valid <= 1'b1;
                end
            end

            if (frame_start) begin
                cnt       <= '0;
                bit_cnt   <= '0;
                stop_cnt  <= 1'b0;
                par_err   <= 1'b0;
                frame_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: an 8N1 instance and an 8E1 instance, each
// on its own serial line, with a reduced bit period to keep runs short.
module tb_uart_rx_core;

    localparam int SYS_CLK = 50_000_000;
    localparam int BAUD    = 500_000;
    localparam int DIV     = SYS_CLK / BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       line = 1'b1;
    logic       line_p = 1'b1;
    logic [7:0] data, data_p;
    logic       valid, valid_p, err, err_p, busy, busy_p;

    int assert_cnt = 0;
    int fail_cnt   = 0;

    int         valid_cnt = 0, err_cnt = 0, valid_cnt_p = 0, err_cnt_p = 0;
    logic [7:0] last_data = 8'h00, last_data_p = 8'h00;
    logic [7:0] rx_log[$];

    always #5 clk = ~clk;

    uart_rx_core #(
        .P_SYSTEM_CLK(SYS_CLK), .P_UART_BUADRATE(BAUD), .P_UART_DATA_WIDTH(8),
        .P_UART_STOP_WIDTH(1), .P_UART_CHECK(0)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(line),
        .o_user_rx_data(data), .o_user_rx_valid(valid),
        .o_user_rx_err(err), .o_user_rx_busy(busy)
    );

    uart_rx_core #(
        .P_SYSTEM_CLK(SYS_CLK), .P_UART_BUADRATE(BAUD), .P_UART_DATA_WIDTH(8),
        .P_UART_STOP_WIDTH(1), .P_UART_CHECK(2)
    ) dut_p (
        .i_clk(clk), .i_rst(rst), .i_uart_rx(line_p),
        .o_user_rx_data(data_p), .o_user_rx_valid(valid_p),
        .o_user_rx_err(err_p), .o_user_rx_busy(busy_p)
    );

    // Pulse monitor: counts valid/err pulses and logs the data seen with them.
    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            rx_log.push_back(data);
        end
        if (err) err_cnt++;
        if (valid || err) last_data = data;
        if (valid_p) valid_cnt_p++;
        if (err_p) err_cnt_p++;
        if (valid_p || err_p) last_data_p = data_p;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_cnt++;
        if (observed !== expected) begin
            fail_cnt++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic driveLine(input bit sel, input logic v, input int cycles);
        if (sel) line_p = v;
        else     line   = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic applyStimulus(input bit sel, input logic [7:0] d, input bit par_on,
                                 input logic par_bit, input logic stop_val);
        driveLine(sel, 1'b0, DIV);
        for (int i = 0; i < 8; i++) driveLine(sel, d[i], DIV);
        if (par_on) driveLine(sel, par_bit, DIV);
        driveLine(sel, stop_val, DIV);
    endtask

    int v0, e0, vp0, ep0, log0;

    initial begin
        @(negedge clk);
        repeat (4) @(negedge clk);
        checkOutput("reset_data", 32'(data), 32'h00);
        checkOutput("reset_valid", 32'(valid), 32'h0);
        checkOutput("reset_err", 32'(err), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        $display("[TB] frame 0x55 8N1");
        v0 = valid_cnt; e0 = err_cnt;
        applyStimulus(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        driveLine(1'b0, 1'b1, DIV);
        checkOutput("f55_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        checkOutput("f55_err_pulses", 32'(err_cnt - e0), 32'd0);
        checkOutput("f55_data", 32'(data), 32'h55);

        $display("[TB] short low glitch");
        v0 = valid_cnt; e0 = err_cnt;
        driveLine(1'b0, 1'b0, DIV / 5);
        checkOutput("glitch_busy_high", 32'(busy), 32'h1);
        driveLine(1'b0, 1'b1, 2 * DIV);
        checkOutput("glitch_busy_low", 32'(busy), 32'h0);
        checkOutput("glitch_valid_pulses", 32'(valid_cnt - v0), 32'd0);
        checkOutput("glitch_err_pulses", 32'(err_cnt - e0), 32'd0);

        $display("[TB] frame 0xA3 with low stop bit");
        v0 = valid_cnt; e0 = err_cnt;
        applyStimulus(1'b0, 8'hA3, 1'b0, 1'b0, 1'b0);
        driveLine(1'b0, 1'b1, 2 * DIV);
        checkOutput("fA3_err_pulses", 32'(err_cnt - e0), 32'd1);
        checkOutput("fA3_valid_pulses", 32'(valid_cnt - v0), 32'd0);
        checkOutput("fA3_data", 32'(last_data), 32'hA3);

        $display("[TB] even parity frames 0x07");
        vp0 = valid_cnt_p; ep0 = err_cnt_p;
        applyStimulus(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        driveLine(1'b1, 1'b1, DIV);
        checkOutput("par0_err_pulses", 32'(err_cnt_p - ep0), 32'd1);
        checkOutput("par0_valid_pulses", 32'(valid_cnt_p - vp0), 32'd0);
        vp0 = valid_cnt_p; ep0 = err_cnt_p;
        applyStimulus(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
        driveLine(1'b1, 1'b1, DIV);
        checkOutput("par1_valid_pulses", 32'(valid_cnt_p - vp0), 32'd1);
        checkOutput("par1_err_pulses", 32'(err_cnt_p - ep0), 32'd0);
        checkOutput("par1_data", 32'(last_data_p), 32'h07);

        $display("[TB] reset during bit 4, then frame 0x3C");
        v0 = valid_cnt; e0 = err_cnt;
        driveLine(1'b0, 1'b0, DIV);
        for (int i = 0; i < 4; i++) driveLine(1'b0, 1'b0, DIV);
        driveLine(1'b0, 1'b1, DIV / 2);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_busy", 32'(busy), 32'h0);
        checkOutput("abort_data_cleared", 32'(data), 32'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        driveLine(1'b0, 1'b1, 3 * DIV);
        checkOutput("abort_no_pulse", 32'((valid_cnt - v0) + (err_cnt - e0)), 32'd0);
        applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
        driveLine(1'b0, 1'b1, DIV);
        checkOutput("f3C_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        checkOutput("f3C_data", 32'(last_data), 32'h3C);

        $display("[TB] back-to-back 0x00, 0xFF");
        v0 = valid_cnt; e0 = err_cnt; log0 = rx_log.size();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
        driveLine(1'b0, 1'b1, 2 * DIV);
        checkOutput("b2b_valid_pulses", 32'(valid_cnt - v0), 32'd2);
        checkOutput("b2b_err_pulses", 32'(err_cnt - e0), 32'd0);
        if (rx_log.size() >= log0 + 2) begin
            checkOutput("b2b_first", 32'(rx_log[log0]), 32'h00);
            checkOutput("b2b_second", 32'(rx_log[log0 + 1]), 32'hFF);
        end else begin
            checkOutput("b2b_log_len", 32'(rx_log.size() - log0), 32'd2);
        end
        checkOutput("b2b_busy_idle", 32'(busy), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
